// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one external memory port between the I-side (port 0) and D-side
// (port 1) miss controllers. An owner keeps the bus for its whole
// transaction; owners alternate round-robin with a quiet GAP cycle between
// them. A watchdog frees the bus if memory stops acknowledging.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   mN_addr/re/wr/wdata        requester N address, level requests, write data
//   mN_rdata/ack               read data and ack routed back to requester N
//   mem_addr/re/wr/wdata       external memory request (zero when not owned)
//   mem_rdata/ack              external memory response
//   grant                      registered one-hot owner (bit0 = port 0)
//   timeout_err                one-cycle pulse when the watchdog fires
module mem_bus_arbiter #(
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CTR_BITS       = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [31:0]          m0_addr,
    input  logic                 m0_re,
    input  logic                 m0_wr,
    input  logic [WORD_SIZE-1:0] m0_wdata,
    output logic [WORD_SIZE-1:0] m0_rdata,
    output logic                 m0_ack,

    input  logic [31:0]          m1_addr,
    input  logic                 m1_re,
    input  logic                 m1_wr,
    input  logic [WORD_SIZE-1:0] m1_wdata,
    output logic [WORD_SIZE-1:0] m1_rdata,
    output logic                 m1_ack,

    output logic [31:0]          mem_addr,
    output logic                 mem_re,
    output logic                 mem_wr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,

    output logic [1:0]           grant,
    output logic                 timeout_err
);

    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic [CTR_BITS-1:0] wdog_q, wdog_d;
    logic [1:0]          grant_q, grant_d;
    logic                timeout_err_q, timeout_err_d;

    logic req0;
    logic req1;
    logic own_req;

    assign req0 = m0_re | m0_wr;
    assign req1 = m1_re | m1_wr;

    // State, round-robin pointer, watchdog and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            wdog_q        <= '0;
            grant_q       <= 2'b00;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            wdog_q        <= wdog_d;
            grant_q       <= grant_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Arbitration, release and watchdog next-state logic
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        wdog_d        = wdog_q;
        timeout_err_d = 1'b0;
        own_req       = 1'b0;

        case (state_q)
            IDLE: begin
                // Counter is held at zero so every BUSY entry starts fresh
                wdog_d = '0;
                if (req0 && req1) begin
                    // Tie: the port that did not own last time wins
                    if (last_q) begin
                        state_d = BUSY0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = BUSY1;
                        last_d  = 1'b1;
                    end
                end else if (req0) begin
                    state_d = BUSY0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = BUSY1;
                    last_d  = 1'b1;
                end
            end

            BUSY0, BUSY1: begin
                own_req = (state_q == BUSY0) ? req0 : req1;
                if (!own_req) begin
                    state_d = GAP;
                    wdog_d  = '0;
                end else if (mem_ack) begin
                    wdog_d = '0;
                end else if (wdog_q == CTR_BITS'(TIMEOUT_CYCLES)) begin
                    // Memory went silent: drop the owner, flag it during GAP
                    state_d       = GAP;
                    wdog_d        = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + CTR_BITS'(1);
                end
            end

            GAP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        grant_d = {(state_d == BUSY1), (state_d == BUSY0)};
    end

    // Bus routing from the registered owner; everything is zero when unowned
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_re    = 1'b0;
        mem_wr    = 1'b0;
        m0_ack    = 1'b0;
        m0_rdata  = '0;
        m1_ack    = 1'b0;
        m1_rdata  = '0;

        case (state_q)
            BUSY0: begin
                mem_addr  = ADDR_W'(m0_addr);
                mem_wdata = m0_wdata;
                mem_wr    = m0_wr;
                mem_re    = m0_re & ~m0_wr;
                m0_ack    = mem_ack;
                m0_rdata  = mem_rdata;
            end
            BUSY1: begin
                mem_addr  = ADDR_W'(m1_addr);
                mem_wdata = m1_wdata;
                mem_wr    = m1_wr;
                mem_re    = m1_re & ~m1_wr;
                m1_ack    = mem_ack;
                m1_rdata  = mem_rdata;
            end
            default: begin
            end
        endcase
    end

    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter. Read beats are pushed to a
// scoreboard queue as memory data is driven and popped when the requester
// sees its ack; grant order for the round-robin test is queued the same way.
module tb_mem_bus_arbiter;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic [31:0]  m0_addr, m1_addr;
    logic         m0_re, m0_wr, m1_re, m1_wr;
    logic [W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic         m0_ack, m1_ack;
    logic [31:0]  mem_addr;
    logic         mem_re, mem_wr;
    logic [W-1:0] mem_wdata, mem_rdata;
    logic         mem_ack;
    logic [1:0]   grant;
    logic         timeout_err;

    int n_tests;
    int n_fail;

    // {port, data} of each read beat the bench expects to be delivered
    logic [W:0]   exp_q[$];
    logic [1:0]   exp_grant_q[$];

    mem_bus_arbiter #(
        .WORD_SIZE     (W),
        .TIMEOUT_CYCLES(255),
        .CTR_BITS      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_addr    (m0_addr),
        .m0_re      (m0_re),
        .m0_wr      (m0_wr),
        .m0_wdata   (m0_wdata),
        .m0_rdata   (m0_rdata),
        .m0_ack     (m0_ack),
        .m1_addr    (m1_addr),
        .m1_re      (m1_re),
        .m1_wr      (m1_wr),
        .m1_wdata   (m1_wdata),
        .m1_rdata   (m1_rdata),
        .m1_ack     (m1_ack),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_re = 1'b1; m1_re = 1'b1;
        m0_addr = 32'h0000_0010; m1_addr = 32'h0000_0020;
        m0_wdata = 32'h1111_1111; m1_wdata = 32'h2222_2222;
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        tick();
        tick();
        n_tests++;
        if (grant !== 2'b00) begin
            n_fail++; $display("FAIL reset_grant got=%b want=00", grant);
        end
        n_tests++;
        if ({mem_re, mem_wr, m0_ack, m1_ack, timeout_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got re=%b wr=%b a0=%b a1=%b to=%b want all 0",
                     mem_re, mem_wr, m0_ack, m1_ack, timeout_err);
        end
        n_tests++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data got addr=%h wdata=%h rd0=%h rd1=%h want 0",
                     mem_addr, mem_wdata, m0_rdata, m1_rdata);
        end
        rst = 1'b0;
        mem_ack = 1'b0;
        tick();
        n_tests++;
        if (grant !== 2'b01) begin
            n_fail++; $display("FAIL reset_first_grant got=%b want=01", grant);
        end
        m0_re = 1'b0; m1_re = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_line_read();
        logic [W:0] e;
        m0_addr = 32'h0000_1040; m1_addr = 32'h0000_3000;
        m0_re = 1'b1;
        tick();
        n_tests++;
        if (grant !== 2'b01 || mem_re !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h0000_1040) begin
            n_fail++;
            $display("FAIL read_start got grant=%b re=%b wr=%b addr=%h want 01/1/0/00001040",
                     grant, mem_re, mem_wr, mem_addr);
        end
        for (int i = 0; i < 16; i++) begin
            mem_ack = 1'b1;
            mem_rdata = W'(i);
            exp_q.push_back({1'b0, W'(i)});
            #1;
            n_tests++;
            if ({m1_ack, m0_ack} !== 2'b01 || m1_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL read_ack beat=%0d got a0=%b a1=%b rd1=%h want 1/0/0",
                         i, m0_ack, m1_ack, m1_rdata);
            end
            n_tests++;
            if (mem_re !== 1'b1 || mem_addr !== 32'h0000_1040) begin
                n_fail++;
                $display("FAIL read_bus beat=%0d got re=%b addr=%h want 1/00001040", i, mem_re, mem_addr);
            end
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL read_sb beat=%0d got empty queue want entry", i);
            end else begin
                e = exp_q.pop_front();
                if (e[W] !== 1'b0 || m0_rdata !== e[W-1:0]) begin
                    n_fail++;
                    $display("FAIL read_data beat=%0d got=%h want=%h", i, m0_rdata, e[W-1:0]);
                end
            end
            tick();
        end
        mem_ack = 1'b0;
        m0_re = 1'b0;
        tick();
        n_tests++;
        if (grant !== 2'b00 || mem_re !== 1'b0 || mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL read_gap got grant=%b re=%b addr=%h want 00/0/0", grant, mem_re, mem_addr);
        end
        mem_ack = 1'b1;
        #1;
        n_tests++;
        if ({m1_ack, m0_ack} !== 2'b00 || m0_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL read_gap_ack got a0=%b a1=%b rd0=%h want 0/0/0", m0_ack, m1_ack, m0_rdata);
        end
        mem_ack = 1'b0;
        tick();
        n_tests++;
        if (grant !== 2'b00) begin
            n_fail++; $display("FAIL read_idle got grant=%b want=00", grant);
        end
    endtask

    task automatic test_tie_rr();
        logic [1:0] g;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_addr = 32'h0000_0A00; m1_addr = 32'h0000_0B00;
        exp_grant_q.push_back(2'b01);
        exp_grant_q.push_back(2'b10);
        exp_grant_q.push_back(2'b01);
        exp_grant_q.push_back(2'b10);
        m0_re = 1'b1; m1_re = 1'b1;
        tick();
        for (int t = 0; t < 4; t++) begin
            g = exp_grant_q.pop_front();
            n_tests++;
            if (grant !== g) begin
                n_fail++; $display("FAIL rr_grant txn=%0d got=%b want=%b", t, grant, g);
            end
            n_tests++;
            if (mem_addr !== ((g == 2'b01) ? 32'h0000_0A00 : 32'h0000_0B00)) begin
                n_fail++; $display("FAIL rr_addr txn=%0d got=%h grant_want=%b", t, mem_addr, g);
            end
            mem_ack = 1'b1;
            mem_rdata = W'(100 + t);
            #1;
            n_tests++;
            if ({m1_ack, m0_ack} !== g) begin
                n_fail++; $display("FAIL rr_ack txn=%0d got=%b want=%b", t, {m1_ack, m0_ack}, g);
            end
            mem_ack = 1'b0;
            if (t == 3) begin
                m0_re = 1'b0; m1_re = 1'b0;
            end else if (g == 2'b01) begin
                m0_re = 1'b0;
            end else begin
                m1_re = 1'b0;
            end
            tick();
            n_tests++;
            if (grant !== 2'b00) begin
                n_fail++; $display("FAIL rr_gap txn=%0d got=%b want=00", t, grant);
            end
            if (t < 3) begin
                m0_re = 1'b1; m1_re = 1'b1;
            end
            tick();
            n_tests++;
            if (grant !== 2'b00) begin
                n_fail++; $display("FAIL rr_idle txn=%0d got=%b want=00", t, grant);
            end
            if (t < 3) tick();
        end
    endtask

    task automatic test_write_hold();
        logic [W:0] e;
        m0_addr = 32'h0000_1040;
        m0_re = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            mem_ack = 1'b1;
            mem_rdata = W'(32'h100 + i);
            exp_q.push_back({1'b0, W'(32'h100 + i)});
            if (i == 3) begin
                m1_addr = 32'h0000_2000; m1_wdata = 32'hDEAD_BEEF;
                m1_wr = 1'b1; m1_re = 1'b1;
            end
            #1;
            n_tests++;
            if ({m1_ack, m0_ack} !== 2'b01 || grant !== 2'b01 || mem_wr !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_owner beat=%0d got a0=%b a1=%b grant=%b wr=%b want 1/0/01/0",
                         i, m0_ack, m1_ack, grant, mem_wr);
            end
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL hold_sb beat=%0d got empty queue want entry", i);
            end else begin
                e = exp_q.pop_front();
                if (m0_rdata !== e[W-1:0] || m1_rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL hold_data beat=%0d got rd0=%h rd1=%h want %h/0", i, m0_rdata, m1_rdata, e[W-1:0]);
                end
            end
            tick();
        end
        m0_re = 1'b0;
        mem_rdata = 32'hFFFF_0000;
        tick();
        n_tests++;
        if (grant !== 2'b00 || {m1_ack, m0_ack} !== 2'b00 || mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_gap got grant=%b acks=%b wr=%b want 00/00/0", grant, {m1_ack, m0_ack}, mem_wr);
        end
        tick();
        n_tests++;
        if (grant !== 2'b00 || {m1_ack, m0_ack} !== 2'b00) begin
            n_fail++;
            $display("FAIL hold_idle got grant=%b acks=%b want 00/00", grant, {m1_ack, m0_ack});
        end
        mem_ack = 1'b0;
        tick();
        n_tests++;
        if (grant !== 2'b10 || mem_wr !== 1'b1 || mem_re !== 1'b0) begin
            n_fail++;
            $display("FAIL write_ctrl got grant=%b wr=%b re=%b want 10/1/0", grant, mem_wr, mem_re);
        end
        n_tests++;
        if (mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h0000_2000) begin
            n_fail++;
            $display("FAIL write_data got wdata=%h addr=%h want deadbeef/00002000", mem_wdata, mem_addr);
        end
        mem_ack = 1'b1;
        #1;
        n_tests++;
        if ({m1_ack, m0_ack} !== 2'b10) begin
            n_fail++; $display("FAIL write_ack got=%b want=10", {m1_ack, m0_ack});
        end
        mem_ack = 1'b0;
        m1_wr = 1'b0; m1_re = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_watchdog();
        int   pulses;
        int   first_at;
        logic ack_seen;
        logic [1:0] grant_at_pulse;
        pulses = 0;
        first_at = -1;
        ack_seen = 1'b0;
        grant_at_pulse = 2'b11;
        m0_addr = 32'h0000_1040;
        m0_re = 1'b1;
        mem_ack = 1'b0;
        tick();
        n_tests++;
        if (grant !== 2'b01) begin
            n_fail++; $display("FAIL wd_grant got=%b want=01", grant);
        end
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (m0_ack) ack_seen = 1'b1;
            if (timeout_err) begin
                pulses++;
                if (first_at < 0) begin
                    first_at = i;
                    grant_at_pulse = grant;
                end
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL wd_pulses got=%0d want=1", pulses);
        end
        n_tests++;
        if (first_at != 256) begin
            n_fail++; $display("FAIL wd_latency got=%0d want=256", first_at);
        end
        n_tests++;
        if (grant_at_pulse !== 2'b00 || ack_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_release got grant=%b ack_seen=%b want 00/0", grant_at_pulse, ack_seen);
        end
        m0_re = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_midburst();
        logic [W:0] e;
        m0_addr = 32'h0000_1040;
        m0_re = 1'b1;
        tick();
        n_tests++;
        if (grant !== 2'b01) begin
            n_fail++; $display("FAIL mid_grant got=%b want=01", grant);
        end
        for (int i = 0; i < 5; i++) begin
            mem_ack = 1'b1;
            mem_rdata = W'(32'h200 + i);
            exp_q.push_back({1'b0, W'(32'h200 + i)});
            #1;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL mid_sb beat=%0d got empty queue want entry", i);
            end else begin
                e = exp_q.pop_front();
                if (m0_ack !== 1'b1 || m0_rdata !== e[W-1:0]) begin
                    n_fail++;
                    $display("FAIL mid_beat beat=%0d got ack=%b data=%h want 1/%h", i, m0_ack, m0_rdata, e[W-1:0]);
                end
            end
            tick();
        end
        mem_rdata = 32'h0000_0205;
        m1_re = 1'b1;
        m1_addr = 32'h0000_3000;
        rst = 1'b1;
        tick();
        n_tests++;
        if (grant !== 2'b00 || {mem_re, mem_wr, m0_ack, m1_ack, timeout_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ctrl got grant=%b re=%b wr=%b a0=%b a1=%b to=%b want all 0",
                     grant, mem_re, mem_wr, m0_ack, m1_ack, timeout_err);
        end
        n_tests++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_data got addr=%h wdata=%h rd0=%h rd1=%h want 0",
                     mem_addr, mem_wdata, m0_rdata, m1_rdata);
        end
        rst = 1'b0;
        mem_ack = 1'b0;
        tick();
        n_tests++;
        if (grant !== 2'b01 || mem_addr !== 32'h0000_1040 || mem_re !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_regrant got grant=%b addr=%h re=%b want 01/00001040/1", grant, mem_addr, mem_re);
        end
        m0_re = 1'b0; m1_re = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        m0_addr = '0; m0_re = 1'b0; m0_wr = 1'b0; m0_wdata = '0;
        m1_addr = '0; m1_re = 1'b0; m1_wr = 1'b0; m1_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;

        test_reset();
        test_line_read();
        test_tie_rr();
        test_write_hold();
        test_watchdog();
        test_reset_midburst();

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL sb_drain got=%0d entries want=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop if the sequence above ever stalls
    initial begin
        #200000;
        $display("FAIL global_timeout got=stalled want=finished");
        $fatal(1, "bench timeout");
    end

endmodule
